// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: instruction-memory request/response channel,
// decode-side instruction handshake and the execute-side redirect.
interface instr_fetch_if #(
  parameter int PC_W = 8
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [15:0]     imem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [15:0]     inst_word;
  logic [3:0]      inst_opcode;
  logic [PC_W-1:0] inst_pc;
  logic            redir_valid;
  logic [PC_W-1:0] redir_target;
  logic            busy;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst_word, inst_opcode, inst_pc, busy,
    input  imem_req_ready, imem_rsp_valid, imem_rdata, inst_ready, redir_valid, redir_target
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst_word, inst_opcode, inst_pc, busy,
    output imem_req_ready, imem_rsp_valid, imem_rdata, inst_ready, redir_valid, redir_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue engine: one outstanding imem read, a single output
// register toward decode, and redirect with squash of the in-flight read.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FETCH | no read outstanding; request pc when output slot is free
// S_WAIT  | one read outstanding at req_pc; squash drops its data
module instr_fetch_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst,
  instr_fetch_if.master  bus
);

  typedef enum logic {S_FETCH = 1'b0, S_WAIT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic [PC_W-1:0] inst_pc_q, inst_pc_d;
  logic [15:0]     inst_word_q, inst_word_d;
  logic            inst_valid_q, inst_valid_d;
  logic            squash_q, squash_d;
  logic            req_valid;
  logic            accept;

  // Issue only when the output slot will be free at the response edge.
  assign req_valid = !rst && (state_q == S_FETCH) && (!inst_valid_q || bus.inst_ready);
  assign accept    = req_valid && bus.imem_req_ready;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc_q;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst_word      = inst_word_q;
  assign bus.inst_opcode    = inst_word_q[15:12];
  assign bus.inst_pc        = inst_pc_q;
  assign bus.busy           = (state_q == S_WAIT);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    inst_pc_d    = inst_pc_q;
    inst_word_d  = inst_word_q;
    inst_valid_d = inst_valid_q;
    squash_d     = squash_q;

    if (inst_valid_q && bus.inst_ready) begin
      inst_valid_d = 1'b0;
    end

    case (state_q)
      S_FETCH: begin
        if (accept) begin
          req_pc_d = pc_q;
          state_d  = S_WAIT;
          if (bus.redir_valid) begin
            squash_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          state_d = S_FETCH;
          if (squash_q || bus.redir_valid) begin
            squash_d = 1'b0;
          end else begin
            inst_word_d  = bus.imem_rdata;
            inst_pc_d    = req_pc_q;
            inst_valid_d = 1'b1;
            pc_d         = req_pc_q + PC_W'(1);
          end
        end else if (bus.redir_valid) begin
          squash_d = 1'b1;
        end
      end
      default: state_d = S_FETCH;
    endcase

    // A redirect kills the presented word even if decode takes it this cycle.
    if (bus.redir_valid) begin
      pc_d         = bus.redir_target;
      inst_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      inst_pc_q    <= '0;
      inst_word_q  <= '0;
      inst_valid_q <= 1'b0;
      squash_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      inst_pc_q    <= inst_pc_d;
      inst_word_q  <= inst_word_d;
      inst_valid_q <= inst_valid_d;
      squash_q     <= squash_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory responder, directed scenarios, random
// traffic, and a scoreboard fed at request acceptance and drained at consume.
module tb_instr_fetch_unit;

  localparam int              PC_W     = 8;
  localparam logic [PC_W-1:0] RESET_PC = 8'h00;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] w;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instr_fetch_if #(.PC_W(PC_W)) bus ();

  instr_fetch_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_deliv = 0;

  logic [15:0] mem [256];
  int          lat_cfg   = 1;
  logic        rnd_ready = 1'b0;

  exp_t       q[$];
  logic [7:0] exp_fetch   = RESET_PC;
  logic       outstanding = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // Memory responder: one rsp pulse per accepted request after lat cycles.
  initial begin
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rdata     = 16'h0;
  end

  always begin : mem_model
    logic       a;
    logic [7:0] ad;
    int         cnt;
    logic [7:0] paddr;
    cnt = 0;
    paddr = 8'h00;
    forever begin
      @(negedge clk);
      a  = bus.imem_req_valid && bus.imem_req_ready;
      ad = bus.imem_addr;
      @(posedge clk);
      #1;
      if (a) begin
        cnt   = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
        paddr = ad;
      end
      bus.imem_rsp_valid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rdata     = mem[paddr];
        end
      end
      bus.imem_req_ready = rnd_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
    end
  end

  // Scoreboard monitor: a word pushed at acceptance must be the next one consumed.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      q.delete();
      exp_fetch   = RESET_PC;
      outstanding = 1'b0;
    end else begin
      cyc++;
      chk("busy", 32'(bus.busy), 32'(outstanding));
      if (outstanding || (bus.inst_valid && !bus.inst_ready))
        chk("req_valid_off", 32'(bus.imem_req_valid), 32'd0);
      else
        chk("req_valid_on", 32'(bus.imem_req_valid), 32'd1);

      if (bus.inst_valid && bus.inst_ready && !bus.redir_valid) begin
        n_deliv++;
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: actual pc=%0h word=%0h expected none", bus.inst_pc, bus.inst_word);
        end else begin
          e = q.pop_front();
          chk("sb_pc", 32'(bus.inst_pc), 32'(e.pc));
          chk("sb_word", 32'(bus.inst_word), 32'(e.w));
          chk("sb_opcode", 32'(bus.inst_opcode), 32'(e.w[15:12]));
        end
      end

      if (bus.imem_req_valid && bus.imem_req_ready) begin
        chk("req_addr", 32'(bus.imem_addr), 32'(exp_fetch));
        if (!bus.redir_valid) begin
          e.pc = exp_fetch;
          e.w  = mem[exp_fetch];
          q.push_back(e);
        end
        exp_fetch   = exp_fetch + 8'd1;
        outstanding = 1'b1;
      end else if (bus.imem_rsp_valid && outstanding) begin
        outstanding = 1'b0;
      end

      if (bus.redir_valid) begin
        q.delete();
        exp_fetch = bus.redir_target;
      end
    end
  end

  task automatic do_reset(input int hold);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.redir_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'(RESET_PC));
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_opcode", 32'(bus.inst_opcode), 32'd0);
    chk("rst_inst_pc", 32'(bus.inst_pc), 32'd0);
    @(posedge clk);
    repeat (hold) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_accept(output logic [7:0] a, output logic saw_iv);
    saw_iv = 1'b0;
    a = 8'h00;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.inst_valid) saw_iv = 1'b1;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        a = bus.imem_addr;
        return;
      end
    end
    timeout("wait_accept");
  endtask

  task automatic wait_accept_addr(input logic [7:0] target);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.imem_req_valid && bus.imem_req_ready && bus.imem_addr == target) return;
    end
    timeout("wait_accept_addr");
  endtask

  task automatic wait_deliver(output logic [7:0] pc, output logic [15:0] w, output int c);
    pc = 8'h00;
    w = 16'h0;
    c = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.inst_valid && bus.inst_ready && !bus.redir_valid) begin
        pc = bus.inst_pc;
        w  = bus.inst_word;
        c  = cyc;
        return;
      end
    end
    timeout("wait_deliver");
  endtask

  task automatic redirect(input logic [7:0] target);
    @(posedge clk);
    #1;
    bus.redir_valid  = 1'b1;
    bus.redir_target = target;
    @(posedge clk);
    #1;
    bus.redir_valid = 1'b0;
  endtask

  initial begin : stim
    logic [3:0]  opc [4];
    logic [7:0]  a;
    logic        saw;
    logic [7:0]  pc;
    logic [15:0] w;
    int          c;
    int          c_prev;
    int          d0;
    int          ok;

    bus.inst_ready   = 1'b1;
    bus.redir_valid  = 1'b0;
    bus.redir_target = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1123;
    mem[1] = 16'h2204;
    mem[2] = 16'h3356;
    mem[3] = 16'hA010;
    opc[0] = 4'h1;
    opc[1] = 4'h2;
    opc[2] = 4'h3;
    opc[3] = 4'hA;

    // Free run, 1-cycle memory, decode always ready.
    lat_cfg = 1;
    do_reset(0);
    c_prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_deliver(pc, w, c);
      chk("run_pc", 32'(pc), 32'(i));
      chk("run_opcode", 32'(w[15:12]), 32'(opc[i]));
      if (i > 0) chk("run_interval", 32'(c - c_prev), 32'd2);
      c_prev = c;
    end

    // Backpressure on the first word.
    bus.inst_ready = 1'b0;
    do_reset(0);
    ok = 0;
    for (int i = 0; i < 50 && ok == 0; i++) begin
      @(negedge clk);
      if (bus.inst_valid) ok = 1;
    end
    if (ok == 0) timeout("bp_first_word");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_hold_word", 32'(bus.inst_word), 32'h1123);
      chk("bp_req_off", 32'(bus.imem_req_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    chk("bp_req_on", 32'(bus.imem_req_valid), 32'd1);
    chk("bp_req_addr", 32'(bus.imem_addr), 32'd1);

    // Redirect while a 3-cycle read of addr 2 is outstanding.
    lat_cfg = 3;
    do_reset(0);
    wait_accept_addr(8'h02);
    redirect(8'h40);
    wait_accept(a, saw);
    chk("rw_next_addr", 32'(a), 32'h40);
    chk("rw_no_stale", 32'(saw), 32'd0);
    wait_deliver(pc, w, c);
    chk("rw_inst_pc", 32'(pc), 32'h40);

    // Redirect in the same cycle as the response.
    lat_cfg = 1;
    wait_accept(a, saw);
    @(posedge clk);
    #1;
    bus.redir_valid  = 1'b1;
    bus.redir_target = 8'h10;
    @(posedge clk);
    #1;
    bus.redir_valid = 1'b0;
    wait_accept(a, saw);
    chk("rc_next_addr", 32'(a), 32'h10);
    chk("rc_no_deliver", 32'(saw), 32'd0);

    // PC wrap from all-ones.
    redirect(8'hFF);
    wait_deliver(pc, w, c);
    chk("wrap_pc", 32'(pc), 32'hFF);
    chk("wrap_word", 32'(w), 32'(mem[255]));
    chk("wrap_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("wrap_req_addr", 32'(bus.imem_addr), 32'h00);

    // Reset while WAIT; the late response lands during reset.
    lat_cfg = 3;
    wait_accept(a, saw);
    do_reset(2);
    wait_deliver(pc, w, c);
    chk("mid_rst_pc", 32'(pc), 32'(RESET_PC));
    chk("mid_rst_word", 32'(w), 32'(mem[RESET_PC]));

    // Random traffic: latency, memory ready, decode ready and redirects.
    lat_cfg   = 0;
    rnd_ready = 1'b1;
    d0 = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      bus.inst_ready = ($urandom_range(0, 9) < 7);
      if (bus.redir_valid) begin
        bus.redir_valid = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        bus.redir_valid  = 1'b1;
        bus.redir_target = 8'($urandom);
      end
    end
    @(posedge clk);
    #1;
    bus.redir_valid = 1'b0;
    bus.inst_ready  = 1'b1;
    repeat (20) @(posedge clk);
    tests++;
    if (n_deliv - d0 < 150) begin
      fails++;
      $display("FAIL rand_throughput: actual=%0d deliveries expected>=150", n_deliv - d0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch and issue engine. It is the producer side of the opcode/instruction interface that the control decoder consumes. It keeps the PC, issues word reads to instruction memory over a valid/ready request channel, and presents each fetched 16-bit instruction to decode over a valid/ready handshake. It redirects on jump, jeq-taken or jr targets that the execute side resolves, and squashes in-flight fetches when it does.

Parameters:
PC_W, 8, PC and instruction-memory word-address width.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_addr  output  PC_W  word address of request
imem_rsp_valid  input  1  read data valid (one pulse per accepted request)
imem_rdata  input  16  instruction word
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode consumes instruction this cycle
inst_word  output  16  full instruction
inst_opcode  output  4  inst_word[15:12], feeds decoder opcode input
inst_pc  output  PC_W  address the instruction was fetched from
redir_valid  input  1  one-cycle redirect pulse (jump/jeq taken/jr)
redir_target  input  PC_W  new PC
busy  output  1  high while a request is outstanding (WAIT)

Behaviour:
- Interface: single clock clk; reset rst is synchronous, active-high.
- Reset (rst sampled high): pc=RESET_PC, state=FETCH, squash=0, inst_valid=0, inst_word=0, inst_pc=0, busy=0. imem_req_valid is combinational, so it is 0 while rst is high. rst overrides every other input, including a mid-transaction response, which is ignored.
- States: FETCH, WAIT.
- FETCH: imem_req_valid = !inst_valid || inst_ready; imem_addr = pc. When imem_req_valid && imem_req_ready: latch req_pc=pc and go to WAIT.
- WAIT: busy=1, imem_req_valid=0. At most one request is outstanding.
  - On imem_rsp_valid with squash=0: inst_word<=imem_rdata, inst_pc<=req_pc, inst_valid<=1, pc<=req_pc+1, go to FETCH.
  - On imem_rsp_valid with squash=1: discard data, squash<=0, go to FETCH.
- Output register: inst_valid clears on inst_valid && inst_ready unless refilled in the same edge. Refill cannot collide with an unconsumed word, by the FETCH issue rule. inst_word and inst_pc hold while inst_valid=1 && inst_ready=0.
- Response arrives no earlier than the cycle after acceptance. Minimum issue interval is 2 cycles per instruction.
- PC arithmetic: pc+1 modulo 2^PC_W. All-ones wraps to 0 with no flag.
- Redirect (redir_valid=1) has priority over all non-reset events:
  - pc<=redir_target and inst_valid<=0. This flushes the output even if inst_ready is high the same cycle; that word counts as not consumed.
  - In WAIT without imem_rsp_valid: squash<=1 and stay in WAIT.
  - In WAIT with imem_rsp_valid the same cycle: drop the data, squash<=0, go to FETCH.
  - In FETCH with a request accepted the same cycle: go to WAIT with squash<=1.
  - In FETCH with no acceptance: stay in FETCH. The next imem_addr=redir_target.
  - A second redirect while squash=1 only updates pc.
- imem_addr may change while imem_req_valid is held only because of a redirect.
- inst_opcode is always inst_word[15:12], including 0 after reset. The decoder treats 0 as its idle opcode.

Test Plan:
- Reset then free run, memory ready=1 with 1-cycle latency, mem[0..3]=16'h1123,2204,3356,A010: inst_valid pulses every 2 cycles. Outputs are inst_pc 0,1,2,3, inst_opcode 1,2,3,A, and imem_addr sequence 0,1,2,3.
- Backpressure: inst_ready=0 for 5 cycles after the first word. inst_word=16'h1123 holds, and imem_req_valid stays 0 until inst_ready=1. On that cycle a request for addr 1 issues.
- Redirect in WAIT: memory latency 3, redir_valid with target 8'h40 one cycle after accept of addr 2. The addr-2 response is dropped (inst_valid stays 0), the next request is addr 8'h40, and the next inst_pc is 8'h40.
- Redirect coincident with response: rsp_valid and redir_valid (target 8'h10) in the same cycle. No instruction is delivered and the next imem_addr is 8'h10.
- Wrap: PC_W=8, redirect to 8'hFF, then run. The instruction at inst_pc=8'hFF is followed by a request for address 8'h00.
- Reset mid-operation: assert rst in WAIT with inst_valid=1. The next cycle shows inst_valid=0, busy=0, imem_addr=RESET_PC. A late rsp_valid arriving during rst is ignored.
